// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scroller
// Description : Spawns and scrolls the single active pipe, drives its edge
//               coordinates to the collision checker and keeps a two-digit
//               BCD score. Follows the checker's Initial/Lose state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_scroller #(
  parameter int          SCREEN_W = 640,
  parameter int          PIPE_W   = 60,
  parameter int          SPEED    = 2,
  parameter int          GAP_MIN  = 60,
  parameter int          GAP_H    = 120,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       Start,
  input  logic       Tick,
  input  logic       Lose,
  input  logic       Initial,
  input  logic [9:0] Bird_X_L,
  output logic [9:0] X_Edge_Left,
  output logic [9:0] X_Edge_Right,
  output logic [9:0] Y_Edge_Top,
  output logic [9:0] Y_Edge_Bottom,
  output logic [7:0] Score,
  output logic       Score_Pulse,
  output logic       Pipe_Active
);

  localparam logic [9:0] c_SPAWN_X = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] c_PIPE_W  = 10'(PIPE_W);
  localparam logic [9:0] c_SPEED   = 10'(SPEED);
  localparam logic [9:0] c_GAP_MIN = 10'(GAP_MIN);
  localparam logic [9:0] c_GAP_H   = 10'(GAP_H);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_RUN    = 3'b010,
    S_FREEZE = 3'b100
  } state_t;

  state_t      r_state;
  logic [9:0]  r_xr;
  logic [9:0]  r_top;
  logic        r_passed;
  logic [15:0] r_lfsr;
  logic [7:0]  r_score;
  logic        r_pulse;

  logic        w_lfsr_fb;
  logic [9:0]  w_spawn_top;
  logic [7:0]  w_score_inc;
  logic        w_score_hit;

  // Taps 16,14,13,11 of the Fibonacci LFSR, shifting toward the MSB
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_spawn_top = c_GAP_MIN + {2'b00, r_lfsr[7:0]};
  // The point is taken from the registered edge, one edge after it crosses
  assign w_score_hit = !r_passed && (r_xr < Bird_X_L);

  // Two-digit BCD increment with 99 wrapping to 00
  always_comb begin
    w_score_inc = r_score;
    if (r_score[3:0] == 4'd9) begin
      w_score_inc[3:0] = 4'd0;
      w_score_inc[7:4] = (r_score[7:4] == 4'd9) ? 4'd0 : r_score[7:4] + 4'd1;
    end else begin
      w_score_inc[3:0] = r_score[3:0] + 4'd1;
    end
  end

  // Free-running random source for the gap position, advances every cycle
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Game state machine: pipe position, gap, pass flag and score
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_xr     <= c_SPAWN_X;
      r_top    <= c_GAP_MIN;
      r_passed <= 1'b0;
      r_score  <= 8'h00;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_score  <= 8'h00;
            r_xr     <= c_SPAWN_X;
            r_top    <= w_spawn_top;
            r_passed <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (Initial) begin
            r_xr    <= c_SPAWN_X;
            r_state <= S_IDLE;
          end else if (Lose) begin
            // Losing freezes the pipe exactly where it is, even on a Tick
            r_state <= S_FREEZE;
          end else begin
            if (w_score_hit) begin
              r_passed <= 1'b1;
              r_score  <= w_score_inc;
              r_pulse  <= 1'b1;
            end
            if (Tick) begin
              if (r_xr <= c_SPEED) begin
                // Respawn clears the pass flag, overriding a same-cycle hit
                r_xr     <= c_SPAWN_X;
                r_top    <= w_spawn_top;
                r_passed <= 1'b0;
              end else begin
                r_xr <= r_xr - c_SPEED;
              end
            end
          end
        end
        S_FREEZE: begin
          if (Initial) begin
            r_xr    <= c_SPAWN_X;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_xr    <= c_SPAWN_X;
        end
      endcase
    end
  end

  assign X_Edge_Right  = r_xr;
  assign X_Edge_Left   = (r_xr >= c_PIPE_W) ? (r_xr - c_PIPE_W) : 10'd0;
  assign Y_Edge_Top    = r_top;
  assign Y_Edge_Bottom = r_top + c_GAP_H;
  assign Score         = r_score;
  assign Score_Pulse   = r_pulse;
  assign Pipe_Active   = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_scroller
// Description : Self-checking bench for pipe_scroller: directed scenarios
//               followed by randomized play against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_scroller;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       Start, Tick, Lose, Initial;
  logic [9:0] Bird_X_L;
  logic [9:0] X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom;
  logic [7:0] Score;
  logic       Score_Pulse, Pipe_Active;

  pipe_scroller dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .Start        (Start),
    .Tick         (Tick),
    .Lose         (Lose),
    .Initial      (Initial),
    .Bird_X_L     (Bird_X_L),
    .X_Edge_Left  (X_Edge_Left),
    .X_Edge_Right (X_Edge_Right),
    .Y_Edge_Top   (Y_Edge_Top),
    .Y_Edge_Bottom(Y_Edge_Bottom),
    .Score        (Score),
    .Score_Pulse  (Score_Pulse),
    .Pipe_Active  (Pipe_Active)
  );

  bit clk_en = 1'b0;
  bit chk_en = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    wait (clk_en);
    forever #5 Clk = ~Clk;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 frozen; score kept as a plain 0..99 integer
  int          m_mode, m_xr, m_top, m_score;
  bit          m_passed, m_pulse;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_xr = 700; m_top = 60; m_score = 0;
    m_passed = 1'b0; m_pulse = 1'b0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_spawn(input logic [15:0] l);
    m_xr = 700;
    m_top = 60 + int'(l[7:0]);
    m_passed = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] lf;
    lf = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_pulse = 1'b0;
    case (m_mode)
      0: if (Start) begin m_score = 0; model_spawn(lf); m_mode = 1; end
      1: begin
        if (Initial) begin m_mode = 0; m_xr = 700; end
        else if (Lose) m_mode = 2;
        else begin
          if (!m_passed && m_xr < int'(Bird_X_L)) begin
            m_score = (m_score + 1) % 100; m_pulse = 1'b1; m_passed = 1'b1;
          end
          if (Tick) begin
            if (m_xr <= 2) model_spawn(lf);
            else m_xr = m_xr - 2;
          end
        end
      end
      default: if (Initial) begin m_mode = 0; m_xr = 700; end
    endcase
  endtask

  always @(negedge reset_n) model_reset();
  always @(posedge Clk) if (reset_n) model_step();

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      check("m_right",  int'(X_Edge_Right), m_xr);
      check("m_left",   int'(X_Edge_Left), (m_xr >= 60) ? m_xr - 60 : 0);
      check("m_top",    int'(Y_Edge_Top), m_top);
      check("m_bottom", int'(Y_Edge_Bottom), m_top + 120);
      check("m_score",  int'(Score), (m_score / 10) * 16 + (m_score % 10));
      check("m_pulse",  int'(Score_Pulse), int'(m_pulse));
      check("m_active", int'(Pipe_Active), (m_mode == 1) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_right"},  int'(X_Edge_Right), 700);
    check({tag, "_left"},   int'(X_Edge_Left), 640);
    check({tag, "_top"},    int'(Y_Edge_Top), 60);
    check({tag, "_bottom"}, int'(Y_Edge_Bottom), 180);
    check({tag, "_score"},  int'(Score), 0);
    check({tag, "_pulse"},  int'(Score_Pulse), 0);
    check({tag, "_active"}, int'(Pipe_Active), 0);
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cnt, cyc, r, top0;
    Start = 0; Tick = 0; Lose = 0; Initial = 0; Bird_X_L = 10'd100;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    // Reset applied with no clock running
    check("rst_left",   int'(X_Edge_Left), 640);
    check("rst_right",  int'(X_Edge_Right), 700);
    check("rst_top",    int'(Y_Edge_Top), 60);
    check("rst_bottom", int'(Y_Edge_Bottom), 180);
    check("rst_score",  int'(Score), 0);
    check("rst_active", int'(Pipe_Active), 0);
    check("rst_pulse",  int'(Score_Pulse), 0);

    clk_en = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Ticks without Start leave the pipe parked
    Tick = 1; repeat (100) step(); Tick = 0;
    check("idle_right", int'(X_Edge_Right), 700);
    check("idle_left",  int'(X_Edge_Left), 640);

    // Start and scroll
    Start = 1; step(); Start = 0;
    check("start_active", int'(Pipe_Active), 1);
    check("start_right",  int'(X_Edge_Right), 700);
    Tick = 1; repeat (10) step();
    check("scroll_right", int'(X_Edge_Right), 680);
    check("scroll_left",  int'(X_Edge_Left), 620);
    top0 = int'(Y_Edge_Top);
    check("scroll_top_range", int'(top0 >= 60 && top0 <= 315), 1);
    check("scroll_bottom", int'(Y_Edge_Bottom), top0 + 120);

    // Scoring with bird at x=100
    repeat (291) step();
    Tick = 0;
    check("pre_score_right", int'(X_Edge_Right), 98);
    check("pre_score", int'(Score), 0);
    step();
    check("score_01", int'(Score), 'h01);
    check("score_pulse_hi", int'(Score_Pulse), 1);
    step();
    check("score_pulse_lo", int'(Score_Pulse), 0);
    Tick = 1; repeat (20) step();
    check("score_held_01", int'(Score), 'h01);

    // Left edge saturation and respawn
    repeat (9) step();
    check("sat_right", int'(X_Edge_Right), 40);
    check("sat_left",  int'(X_Edge_Left), 0);
    repeat (19) step();
    check("pre_spawn_right", int'(X_Edge_Right), 2);
    step();
    check("respawn_right", int'(X_Edge_Right), 700);
    check("respawn_left",  int'(X_Edge_Left), 640);

    // Lose with a simultaneous Tick freezes the pipe
    repeat (100) step();
    check("pre_lose_right", int'(X_Edge_Right), 500);
    Lose = 1; step(); Lose = 0;
    check("lose_right",  int'(X_Edge_Right), 500);
    check("lose_active", int'(Pipe_Active), 0);
    repeat (10) step();
    check("freeze_right", int'(X_Edge_Right), 500);
    Tick = 0;
    Initial = 1; step(); Initial = 0;
    check("init_right", int'(X_Edge_Right), 700);
    check("init_score", int'(Score), 'h01);
    Start = 1; step(); Start = 0;
    check("restart_score",  int'(Score), 'h00);
    check("restart_active", int'(Pipe_Active), 1);

    // Score carries: one point per pipe with the bird far right
    Bird_X_L = 10'd1000; Tick = 1;
    cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 5000) begin step(); cyc++; if (Score_Pulse) cnt++; end
    check("pulses_to_10", cnt, 10);
    check("score_carry_10", int'(Score), 'h10);
    while (cnt < 100 && cyc < 40000) begin step(); cyc++; if (Score_Pulse) cnt++; end
    check("pulses_to_100", cnt, 100);
    check("score_wrap_00", int'(Score), 'h00);

    // Asynchronous reset in the middle of a run
    Tick = 0;
    Initial = 1; step(); Initial = 0;
    Start = 1; step(); Start = 0;
    Tick = 1; repeat (200) step(); Tick = 0;
    check("mid_right", int'(X_Edge_Right), 300);
    mid_cycle_reset("arst");
    step();
    check("arst_after_pulse", int'(Score_Pulse), 0);

    // Randomized play against the model
    for (int i = 0; i < 20000; i++) begin
      Start = ($urandom_range(0, 19) == 0);
      Tick  = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1999);
      Lose    = (r == 0);
      Initial = (r == 1 || r == 2);
      if (i % 50 == 0) Bird_X_L = 10'($urandom_range(0, 1023));
      if (i == 10000) mid_cycle_reset("rnd_arst");
      step();
    end
    Start = 0; Tick = 0; Lose = 0; Initial = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_scroller.md
# pipe_scroller

Generates and scrolls the single active pipe for the flappy game and keeps the score. It drives the pipe edge coordinates consumed by the collision checker (X_Edge_Left/Right, Y_Edge_Top/Bottom). It follows that checker's Initial/Lose state outputs so the pipe freezes on a loss and parks when the game returns to initial. The score feeds the display path.

## Interface
Parameters:
- SCREEN_W, 640: visible width in pixels; spawn reference.
- PIPE_W, 60: pipe width; SCREEN_W+PIPE_W must be < 1024.
- SPEED, 2: pixels moved per Tick; 1..PIPE_W.
- GAP_MIN, 60: minimum Y_Edge_Top.
- GAP_H, 120: gap height; GAP_MIN+255+GAP_H must be ≤ 479.
- SEED, 16'hACE1: LFSR reset value; nonzero.

Ports:
- Clk, input, 1: system clock.
- reset_n, input, 1: one clock; reset is asynchronous and active-low.
- Start, input, 1: begin a run (same Start the checker sees).
- Tick, input, 1: frame-rate one-cycle pulse.
- Lose, input, 1: checker Q_Lose.
- Initial, input, 1: checker Q_Initial.
- Bird_X_L, input, 10: bird left edge, used for scoring.
- X_Edge_Left, output, 10: pipe left edge.
- X_Edge_Right, output, 10: pipe right edge.
- Y_Edge_Top, output, 10: bottom of the upper pipe section.
- Y_Edge_Bottom, output, 10: top of the lower pipe section.
- Score, output, 8: two BCD digits, {tens, ones}.
- Score_Pulse, output, 1: one-cycle pulse per point.
- Pipe_Active, output, 1: high in RUN.

## Operation
- Internal registers:
  - xr[9:0]: right edge.
  - top[9:0].
  - passed: 1 bit.
  - lfsr[15:0]: x^16+x^14+x^13+x^11+1, Fibonacci form; shifts every cycle in every state.
- Outputs:
  - X_Edge_Right = xr.
  - X_Edge_Left = (xr ≥ PIPE_W) ? xr−PIPE_W : 0 (saturating).
  - Y_Edge_Top = top.
  - Y_Edge_Bottom = top+GAP_H.
- Spawn action:
  - xr ← SCREEN_W+PIPE_W.
  - top ← GAP_MIN + {2'b0, lfsr[7:0]}.
  - passed ← 0.
- States are IDLE, RUN and FREEZE, one-hot.
- IDLE:
  - Pipe parked at the spawn position; score held.
  - On Start: Score ← 00, spawn, go to RUN.
- RUN:
  - On Tick with Lose=0:
    - If xr ≤ SPEED: spawn.
    - Else xr ← xr−SPEED.
  - Scoring: when passed=0 and xr < Bird_X_L, then passed ← 1, Score increments in BCD (ones 9→0 carries into tens; 99→00 wraps), and Score_Pulse=1 for that cycle.
  - On Lose: go to FREEZE. Lose has priority over a simultaneous Tick, so there is no move and no spawn.
  - On Initial: go to IDLE and park.
- FREEZE:
  - All outputs held; Tick ignored; no scoring.
  - On Initial: go to IDLE and park (xr ← SCREEN_W+PIPE_W; top and score held).
- Start is ignored outside IDLE.
- A respawn with passed=0 awards no point.
- Arithmetic is unsigned 10-bit throughout. The parameter constraints guarantee there is no overflow.

## Timing
- Reset (async, reset_n=0, no clock needed):
  - State IDLE.
  - xr=SCREEN_W+PIPE_W (X_Edge_Left=640, X_Edge_Right=700).
  - top=GAP_MIN (Y_Edge_Top=60, Y_Edge_Bottom=180).
  - lfsr=SEED; Score=00.
  - Score_Pulse=0, Pipe_Active=0, passed=0.
- Position latency: edges update on the first Clk edge where Tick is sampled high; outputs are registered.
- Score latency: the score check uses registered xr. Score and Score_Pulse update one edge after the edge that brought xr below Bird_X_L.
- Start→RUN: spawn and Pipe_Active=1 are visible after the next edge.
- Reset mid-run: immediate return to reset values. No point is awarded and no pulse is emitted.

## Test plan
- Reset: hold reset_n=0 with no clock → Left=640, Right=700, Top=60, Bottom=180, Score=00, Pipe_Active=0; release, 100 Ticks with no Start → edges unchanged.
- Scroll: Start, then 10 Ticks → Right=680, Left=620; Top is in [60,315]; Bottom=Top+120.
- Score: Bird_X_L=100, Start, 301 Ticks → Right=98; next edge Score=01 and Score_Pulse high exactly 1 cycle; 20 more Ticks → still 01. Preload to 09 → 10; preload to 99 → 00.
- Edge saturation and respawn: at Right=40 → Left=0; Tick at Right=2 → Right=700, Left=640, new Top = 60+lfsr[7:0], passed cleared.
- Lose: Lose and Tick in the same cycle at Right=500 → Right stays 500 and state is FREEZE; further Ticks → no change; Initial → IDLE with Right=700 and Score held; Start → Score=00.
- Async reset mid-RUN (Right=300, Score=05): drop reset_n between clock edges → outputs return to reset values before the next edge; Score_Pulse stays 0.
